sobel_threshold_ctrl: RTL

Frame-synchronous controller for the Sobel edge detector's `Sobel_Threshold` input. It sits beside the detector in the video pipeline:
- Accepts threshold writes from the host/config bus over a valid/ready handshake.
- Changes the threshold only at frame starts, so no frame is ever processed with two thresholds.
- Counts edge pixels from the detector output each frame.
- Optionally closes the loop, stepping the threshold to hold the edge count inside a target band.

---
 rtl/sobel_ctrl_pkg.sv | 50 +++++
 rtl/sobel_threshold_ctrl_if.sv | 24 ++
 rtl/sync_edge_detect.sv | 27 ++
 rtl/sobel_threshold_ctrl.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/sobel_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sobel_ctrl_pkg
// Shared definitions for the Sobel threshold controller:
//   - statistics FSM state type
//   - edge-counter width and saturation value
//   - threshold constants (reset value, auto-mode bounds, target band, step)
//   - auto_step(): one closed-loop threshold decision from a frame edge count
// -----------------------------------------------------------------------------
package sobel_ctrl_pkg;

  // Frame geometry; informational, the counter is sized independently.
  localparam logic [10:0] IMG_HDISP = 11'd640;
  localparam logic [10:0] IMG_VDISP = 11'd480;

  localparam int CNT_W = 22;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  localparam logic [7:0]       THR_DEFAULT = 8'd40;
  localparam logic [7:0]       THR_MIN     = 8'd8;
  localparam logic [CNT_W-1:0] TARGET_LO   = 22'd5000;
  localparam logic [CNT_W-1:0] TARGET_HI   = 22'd20000;
  localparam logic [7:0]       STEP        = 8'd1;

  typedef enum logic [1:0] {
    S_WAITLOW = 2'd0,
    S_ARMED   = 2'd1,
    S_COUNT   = 2'd2,
    S_EVAL    = 2'd3
  } stats_state_t;

  // Returns {change, next_threshold}. Arithmetic is done in 9 bits so that
  // overflow above 255 and borrow below 0 are both visible before clamping.
  function automatic logic [8:0] auto_step(input logic [7:0]       thr,
                                           input logic [CNT_W-1:0] cnt);
    logic [8:0] w_inc;
    logic [8:0] w_dec;
    logic [8:0] w_res;
    w_inc = {1'b0, thr} + {1'b0, STEP};
    w_dec = {1'b0, thr} - {1'b0, STEP};
    w_res = {1'b0, thr};
    if (cnt > TARGET_HI) begin
      w_res = {1'b1, (w_inc[8] ? 8'hFF : w_inc[7:0])};
    end else if (cnt < TARGET_LO) begin
      // w_dec[8] flags a borrow, i.e. the result went below zero.
      w_res = {1'b1, ((w_dec[8] || (w_dec[7:0] < THR_MIN)) ? THR_MIN : w_dec[7:0])};
    end
    return w_res;
  endfunction

endpackage

// File: rtl/sobel_threshold_ctrl_if.sv
// -----------------------------------------------------------------------------
// sobel_threshold_ctrl_if
// Threshold configuration bus between host and controller.
//   cfg_valid     host -> ctrl  write request
//   cfg_ready     ctrl -> host  write can be accepted
//   cfg_threshold host -> ctrl  requested threshold
//   cfg_auto      host -> ctrl  level, enables closed-loop adjustment
//
// Handshake: a write transfers on every rising clk edge where cfg_valid and
// cfg_ready are both high. The host holds cfg_valid and cfg_threshold stable
// until that edge; cfg_ready may fall without a transfer and says nothing
// about cfg_valid. cfg_auto is a plain level and is not part of the handshake.
// -----------------------------------------------------------------------------
interface sobel_threshold_ctrl_if;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_threshold;
  logic       cfg_auto;

  modport master (output cfg_valid, output cfg_threshold, output cfg_auto,
                  input  cfg_ready);
  modport slave  (input  cfg_valid, input  cfg_threshold, input  cfg_auto,
                  output cfg_ready);
endinterface

// File: rtl/sync_edge_detect.sv
// -----------------------------------------------------------------------------
// sync_edge_detect
// Registers a level and reports its edges against the registered copy.
//   clk, rst_n  clock / async active-low reset (copy resets low)
//   i_level     level to watch (already synchronous to clk)
//   o_rise      i_level high while the registered copy is low
//   o_fall      i_level low while the registered copy is high
// The pulses are combinational so the consumer acts on the very edge that
// first samples the new level.
// -----------------------------------------------------------------------------
module sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic i_level,
  output logic o_rise,
  output logic o_fall
);
  logic r_level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_level_q <= 1'b0;
    else        r_level_q <= i_level;
  end

  assign o_rise = i_level & ~r_level_q;
  assign o_fall = ~i_level & r_level_q;
endmodule

// File: rtl/sobel_threshold_ctrl.sv
// -----------------------------------------------------------------------------
// sobel_threshold_ctrl
// Frame-synchronous threshold controller for the Sobel edge detector.
//   clk, rst_n         pixel clock / async active-low reset
//   per_frame_vsync    detector input vsync; threshold changes on its rise
//   post_frame_vsync   detector output vsync; frames edge-pixel statistics
//   post_frame_href    detector output href; only href-high pixels count
//   post_img_Bit       detector edge flag
//   cfg                configuration bus (slave side)
//   Sobel_Threshold    threshold driven into the detector
//   frame_edge_cnt     edge count of the last completed frame
//   frame_done         one-cycle pulse, frame_edge_cnt just updated
//   dbg_state          statistics FSM state
//
// Build option: SOBEL_AUTO_THR_EN adds the closed-loop auto threshold
// (cfg_auto, pending auto value). Without it cfg_auto is ignored.
// -----------------------------------------------------------------------------
module sobel_threshold_ctrl
  import sobel_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   per_frame_vsync,
  input  logic                   post_frame_vsync,
  input  logic                   post_frame_href,
  input  logic                   post_img_Bit,
  sobel_threshold_ctrl_if.slave  cfg,
  output logic [7:0]             Sobel_Threshold,
  output logic [CNT_W-1:0]       frame_edge_cnt,
  output logic                   frame_done,
  output stats_state_t           dbg_state
);

  logic w_pf_rise;
  logic w_pf_fall;
  logic w_po_rise;
  logic w_po_fall;

  sync_edge_detect u_pf_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_level (per_frame_vsync),
    .o_rise  (w_pf_rise),
    .o_fall  (w_pf_fall)
  );

  sync_edge_detect u_po_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_level (post_frame_vsync),
    .o_rise  (w_po_rise),
    .o_fall  (w_po_fall)
  );

  // Only the rise of the input vsync matters for threshold timing.
  logic w_pf_fall_unused;
  assign w_pf_fall_unused = w_pf_fall;

  // ---------------------------------------------------------------------------
  // Statistics FSM
  // ---------------------------------------------------------------------------
  stats_state_t     r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_frame_edge_cnt;
  logic             r_frame_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= S_WAITLOW;
      r_cnt            <= '0;
      r_frame_edge_cnt <= '0;
      r_frame_done     <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        // A frame already in progress (e.g. at reset release) is skipped.
        S_WAITLOW: if (!post_frame_vsync) r_state <= S_ARMED;
        S_ARMED: begin
          if (w_po_rise) begin
            r_cnt   <= '0;
            r_state <= S_COUNT;
          end
        end
        S_COUNT: begin
          if (w_po_fall) begin
            // Latched here so the result and the pulse are both visible
            // during the S_EVAL cycle.
            r_frame_edge_cnt <= r_cnt;
            r_frame_done     <= 1'b1;
            r_state          <= S_EVAL;
          end else if (post_frame_href && post_img_Bit && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_EVAL:  r_state <= S_ARMED;
        default: r_state <= S_WAITLOW;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Threshold register, manual pending path and optional auto pending path
  // ---------------------------------------------------------------------------
  logic [7:0] r_thr;
  logic [7:0] r_pend_thr;
  logic       r_pend_man;
  logic       w_accept;

  assign w_accept = cfg.cfg_valid && !r_pend_man;

`ifdef SOBEL_AUTO_THR_EN
  logic       r_pend_auto;
  logic [7:0] r_auto_thr;
  logic [8:0] w_auto;
  logic       w_eval_auto;

  // Decision uses the count latched on entry to S_EVAL.
  assign w_auto      = auto_step(r_thr, r_frame_edge_cnt);
  assign w_eval_auto = (r_state == S_EVAL) && cfg.cfg_auto && !r_pend_man;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_thr       <= THR_DEFAULT;
      r_pend_thr  <= '0;
      r_pend_man  <= 1'b0;
      r_pend_auto <= 1'b0;
      r_auto_thr  <= '0;
    end else begin
      if (w_pf_rise && r_pend_man) begin
        r_thr      <= r_pend_thr;
        r_pend_man <= 1'b0;
      end else if (w_pf_rise && r_pend_auto) begin
        r_thr       <= r_auto_thr;
        r_pend_auto <= 1'b0;
      end
      if (w_accept) begin
        r_pend_thr  <= cfg.cfg_threshold;
        r_pend_man  <= 1'b1;
        // A manual write always supersedes a pending auto step.
        r_pend_auto <= 1'b0;
      end else if (w_eval_auto && w_auto[8]) begin
        r_auto_thr  <= w_auto[7:0];
        r_pend_auto <= 1'b1;
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_thr      <= THR_DEFAULT;
      r_pend_thr <= '0;
      r_pend_man <= 1'b0;
    end else begin
      if (w_pf_rise && r_pend_man) begin
        r_thr      <= r_pend_thr;
        r_pend_man <= 1'b0;
      end
      if (w_accept) begin
        r_pend_thr <= cfg.cfg_threshold;
        r_pend_man <= 1'b1;
      end
    end
  end
`endif

  assign cfg.cfg_ready    = !r_pend_man;
  assign Sobel_Threshold  = r_thr;
  assign frame_edge_cnt   = r_frame_edge_cnt;
  assign frame_done       = r_frame_done;
  assign dbg_state        = r_state;

endmodule
